// File: rtl/tiny_riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch (I) port and the load/store (D) port.
module tiny_riscv_mem_arbiter #(
    parameter int unsigned WORD_ADDR_BITS = 8
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_N,
    input  logic                      i_I_req,
    input  logic [31:0]               i_I_addr,
    output logic                      o_I_gnt,
    output logic                      o_I_rvalid,
    output logic [31:0]               o_I_rdata,
    input  logic                      i_D_req,
    input  logic                      i_D_we,
    input  logic [3:0]                i_D_wmask,
    input  logic [31:0]               i_D_addr,
    input  logic [31:0]               i_D_wdata,
    output logic                      o_D_gnt,
    output logic                      o_D_rvalid,
    output logic [31:0]               o_D_rdata,
    output logic                      o_ram_en,
    output logic [3:0]                o_ram_we,
    output logic [WORD_ADDR_BITS-1:0] o_ram_addr,
    output logic [31:0]               o_ram_wdata,
    input  logic [31:0]               i_ram_rdata,
    output logic                      o_busy
);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t      state_q, state_d;
    logic        last_winner_q, last_winner_d;
    logic        rd_port_q, rd_port_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        busy_q, busy_d;
    logic        d_wins;

    // Only the word-index bits of each byte address reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_I_addr[31:WORD_ADDR_BITS+2], i_I_addr[1:0],
                                i_D_addr[31:WORD_ADDR_BITS+2], i_D_addr[1:0]};

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        rd_port_d     = rd_port_q;
        i_rvalid_d    = 1'b0;
        d_rvalid_d    = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        o_I_gnt       = 1'b0;
        o_D_gnt       = 1'b0;
        o_ram_en      = 1'b0;
        o_ram_we      = 4'h0;
        o_ram_addr    = '0;
        o_ram_wdata   = 32'h0;
        d_wins        = i_D_req && (!i_I_req || (last_winner_q == PORT_I));

        unique case (state_q)
            ST_IDLE: begin
                if (i_I_req || i_D_req) begin
                    o_ram_en      = 1'b1;
                    last_winner_d = d_wins ? PORT_D : PORT_I;
                    if (d_wins) begin
                        o_D_gnt    = 1'b1;
                        o_ram_addr = i_D_addr[WORD_ADDR_BITS+1:2];
                        if (i_D_we) begin
                            o_ram_we    = i_D_wmask;
                            o_ram_wdata = i_D_wdata;
                        end else begin
                            state_d   = ST_READ_WAIT;
                            rd_port_d = PORT_D;
                        end
                    end else begin
                        o_I_gnt    = 1'b1;
                        o_ram_addr = i_I_addr[WORD_ADDR_BITS+1:2];
                        state_d    = ST_READ_WAIT;
                        rd_port_d  = PORT_I;
                    end
                end
            end
            ST_READ_WAIT: begin
                // RAM data is valid now; steer it into the owning port's register.
                state_d = ST_IDLE;
                if (rd_port_q == PORT_D) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = i_ram_rdata;
                end else begin
                    i_rvalid_d = 1'b1;
                    i_rdata_d  = i_ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || i_rvalid_d || d_rvalid_d;

        if (!i_Rst_N) begin
            o_I_gnt  = 1'b0;
            o_D_gnt  = 1'b0;
            o_ram_en = 1'b0;
            o_ram_we = 4'h0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            state_q       <= ST_IDLE;
            last_winner_q <= PORT_I;
            rd_port_q     <= PORT_I;
            i_rvalid_q    <= 1'b0;
            d_rvalid_q    <= 1'b0;
            i_rdata_q     <= 32'h0;
            d_rdata_q     <= 32'h0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            rd_port_q     <= rd_port_d;
            i_rvalid_q    <= i_rvalid_d;
            d_rvalid_q    <= d_rvalid_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign o_I_rvalid = i_rvalid_q;
    assign o_D_rvalid = d_rvalid_q;
    assign o_I_rdata  = i_rdata_q;
    assign o_D_rdata  = d_rdata_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
// Scoreboard bench for tiny_riscv_mem_arbiter with a byte-maskable sync RAM model.
module tb_tiny_riscv_mem_arbiter;

    logic        i_Clk;
    logic        i_Rst_N;
    logic        i_I_req;
    logic [31:0] i_I_addr;
    logic        o_I_gnt;
    logic        o_I_rvalid;
    logic [31:0] o_I_rdata;
    logic        i_D_req;
    logic        i_D_we;
    logic [3:0]  i_D_wmask;
    logic [31:0] i_D_addr;
    logic [31:0] i_D_wdata;
    logic        o_D_gnt;
    logic        o_D_rvalid;
    logic [31:0] o_D_rdata;
    logic        o_ram_en;
    logic [3:0]  o_ram_we;
    logic [7:0]  o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic [31:0] ram_rdata;
    logic        o_busy;

    tiny_riscv_mem_arbiter #(.WORD_ADDR_BITS(8)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_N    (i_Rst_N),
        .i_I_req    (i_I_req),
        .i_I_addr   (i_I_addr),
        .o_I_gnt    (o_I_gnt),
        .o_I_rvalid (o_I_rvalid),
        .o_I_rdata  (o_I_rdata),
        .i_D_req    (i_D_req),
        .i_D_we     (i_D_we),
        .i_D_wmask  (i_D_wmask),
        .i_D_addr   (i_D_addr),
        .i_D_wdata  (i_D_wdata),
        .o_D_gnt    (o_D_gnt),
        .o_D_rvalid (o_D_rvalid),
        .o_D_rdata  (o_D_rdata),
        .o_ram_en   (o_ram_en),
        .o_ram_we   (o_ram_we),
        .o_ram_addr (o_ram_addr),
        .o_ram_wdata(o_ram_wdata),
        .i_ram_rdata(ram_rdata),
        .o_busy     (o_busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // RAM model with a backdoor preload port.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    always @(posedge i_Clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (o_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_we[b]) mem[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
            if (o_ram_we == 4'h0) ram_rdata <= mem[o_ram_addr];
        end
    end

    logic [31:0] ref_mem [256];
    logic [31:0] i_q_data[$];
    int          i_q_due[$];
    logic [31:0] d_q_data[$];
    int          d_q_due[$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    // Advance one cycle and retire any read results against the scoreboard.
    task automatic step();
        logic [31:0] exp_d;
        int          due;
        @(posedge i_Clk);
        #1;
        cyc++;
        if (o_I_rvalid === 1'b1) begin
            n_checks++;
            if (i_q_data.size() == 0) begin
                n_fail++;
                $display("FAIL i_rvalid_unexpected: cycle %0d rdata %h", cyc, o_I_rdata);
            end else begin
                exp_d = i_q_data.pop_front();
                due   = i_q_due.pop_front();
                if (o_I_rdata !== exp_d || cyc != due) begin
                    n_fail++;
                    $display("FAIL i_read: rdata %h at cycle %0d, expected %h at cycle %0d", o_I_rdata, cyc, exp_d, due);
                end
            end
        end else if (i_q_due.size() > 0 && i_q_due[0] <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL i_rvalid_missing: cycle %0d expected data %h", cyc, i_q_data[0]);
            void'(i_q_data.pop_front());
            void'(i_q_due.pop_front());
        end
        if (o_D_rvalid === 1'b1) begin
            n_checks++;
            if (d_q_data.size() == 0) begin
                n_fail++;
                $display("FAIL d_rvalid_unexpected: cycle %0d rdata %h", cyc, o_D_rdata);
            end else begin
                exp_d = d_q_data.pop_front();
                due   = d_q_due.pop_front();
                if (o_D_rdata !== exp_d || cyc != due) begin
                    n_fail++;
                    $display("FAIL d_read: rdata %h at cycle %0d, expected %h at cycle %0d", o_D_rdata, cyc, exp_d, due);
                end
            end
        end else if (d_q_due.size() > 0 && d_q_due[0] <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_rvalid_missing: cycle %0d expected data %h", cyc, d_q_data[0]);
            void'(d_q_data.pop_front());
            void'(d_q_due.pop_front());
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (i_q_data.size() + d_q_data.size()) > 0; k++) step();
        if ((i_q_data.size() + d_q_data.size()) > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d reads outstanding, expected 0", i_q_data.size() + d_q_data.size());
            i_q_data.delete(); i_q_due.delete(); d_q_data.delete(); d_q_due.delete();
        end
    endtask

    // One D access: wait (bounded) for gnt, check RAM drive, update the scoreboard.
    task automatic d_access(input logic we, input logic [3:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] idx;
        bit         got;
        idx = addr[9:2];
        got = 1'b0;
        i_D_req = 1'b1; i_D_we = we; i_D_wmask = mask; i_D_addr = addr; i_D_wdata = wdata;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (o_D_gnt === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (o_ram_en !== 1'b1 || o_ram_addr !== idx || o_ram_we !== (we ? mask : 4'h0)) begin
                    n_fail++;
                    $display("FAIL d_access_ram: en %b addr %h we %b, expected en 1 addr %h we %b",
                             o_ram_en, o_ram_addr, o_ram_we, idx, (we ? mask : 4'h0));
                end
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    d_q_data.push_back(ref_mem[idx]);
                    d_q_due.push_back(cyc + 2);
                end
            end
            step();
        end
        i_D_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_gnt_timeout: addr %h gnt 0, expected 1", addr);
        end
    endtask

    task automatic preload();
        logic [31:0] v;
        i_Rst_N = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i + 1)};
            if (i == 3) v = 32'h0050_0093;
            if (i == 4) v = 32'h1122_3344;
            pre_we = 1'b1; pre_idx = 8'(i); pre_data = v; ref_mem[i] = v;
            step();
        end
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (o_busy !== 1'b0 || o_I_rvalid !== 1'b0 || o_D_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy %b i_rvalid %b d_rvalid %b, expected 0 0 0", o_busy, o_I_rvalid, o_D_rvalid);
        end
        n_checks++;
        if (o_I_rdata !== 32'h0 || o_D_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: i %h d %h, expected 0 0", o_I_rdata, o_D_rdata);
        end
        i_I_req = 1'b1; i_D_req = 1'b1; i_D_we = 1'b1; i_D_wmask = 4'hF;
        #1;
        n_checks++;
        if (o_I_gnt !== 1'b0 || o_D_gnt !== 1'b0 || o_ram_en !== 1'b0 || o_ram_we !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_forced: gnt %b%b en %b we %b, expected 00 0 0000", o_I_gnt, o_D_gnt, o_ram_en, o_ram_we);
        end
        i_I_req = 1'b0; i_D_req = 1'b0; i_D_we = 1'b0;
        i_Rst_N = 1'b1;
        step();
    endtask

    task automatic test_single_i_read();
        i_I_req = 1'b1; i_I_addr = 32'h0000_000C;
        #1;
        n_checks++;
        if (o_I_gnt !== 1'b1 || o_D_gnt !== 1'b0 || o_ram_en !== 1'b1 || o_ram_addr !== 8'd3 || o_ram_we !== 4'h0) begin
            n_fail++;
            $display("FAIL i_read_issue: gnt %b%b en %b addr %h we %b, expected 10 1 03 0000",
                     o_I_gnt, o_D_gnt, o_ram_en, o_ram_addr, o_ram_we);
        end
        i_q_data.push_back(ref_mem[3]);
        i_q_due.push_back(cyc + 2);
        step();
        i_I_req = 1'b0;
        #1;
        n_checks++;
        if (o_ram_en !== 1'b0 || o_I_gnt !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL i_read_wait: en %b gnt %b busy %b, expected 0 0 1", o_ram_en, o_I_gnt, o_busy);
        end
        step();
        n_checks++;
        if (o_I_rdata !== 32'h0050_0093 || o_D_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_value: rdata %h d_rvalid %b, expected 00500093 0", o_I_rdata, o_D_rvalid);
        end
        step();
        n_checks++;
        if (o_I_rvalid !== 1'b0 || o_I_rdata !== 32'h0050_0093 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_hold: rvalid %b rdata %h busy %b, expected 0 00500093 0", o_I_rvalid, o_I_rdata, o_busy);
        end
    endtask

    task automatic test_byte_write();
        i_D_wdata = 32'hAABB_CCDD;
        d_access(1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD);
        n_checks++;
        if (o_busy !== 1'b0 || o_D_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_read: busy %b rvalid %b, expected 0 0", o_busy, o_D_rvalid);
        end
        d_access(1'b0, 4'h0, 32'h13, 32'h0);
        drain();
        n_checks++;
        if (o_D_rdata !== 32'h1122_CC44) begin
            n_fail++;
            $display("FAIL byte_merge: rdata %h, expected 1122cc44", o_D_rdata);
        end
    endtask

    task automatic test_contention();
        bit exp_d;
        i_Rst_N = 1'b0;
        step();
        i_Rst_N = 1'b1;
        i_I_req = 1'b1; i_I_addr = 32'h20;
        i_D_req = 1'b1; i_D_we = 1'b0; i_D_addr = 32'h24;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if (k % 2 == 0) begin
                exp_d = ((k / 2) % 2) == 0;
                if (o_D_gnt !== exp_d || o_I_gnt !== !exp_d) begin
                    n_fail++;
                    $display("FAIL contention_order: slot %0d gnt I%b D%b, expected I%b D%b", k, o_I_gnt, o_D_gnt, !exp_d, exp_d);
                end
                if (exp_d) begin
                    d_q_data.push_back(ref_mem[9]); d_q_due.push_back(cyc + 2);
                end else begin
                    i_q_data.push_back(ref_mem[8]); i_q_due.push_back(cyc + 2);
                end
            end else if (o_D_gnt !== 1'b0 || o_I_gnt !== 1'b0 || o_ram_en !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_wait: slot %0d gnt I%b D%b en %b, expected 0 0 0", k, o_I_gnt, o_D_gnt, o_ram_en);
            end
            step();
        end
        i_I_req = 1'b0; i_D_req = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        i_D_req = 1'b1; i_D_we = 1'b1; i_D_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            i_D_addr = 32'(4 * k); i_D_wdata = w;
            #1;
            n_checks++;
            if (o_D_gnt !== 1'b1 || o_ram_we !== 4'hF || o_ram_wdata !== w || o_ram_addr !== 8'(k)) begin
                n_fail++;
                $display("FAIL b2b_write: k %0d gnt %b we %b wdata %h addr %h, expected 1 1111 %h %h",
                         k, o_D_gnt, o_ram_we, o_ram_wdata, o_ram_addr, w, 8'(k));
            end
            ref_mem[k] = w;
            step();
        end
        i_D_req = 1'b0; i_D_we = 1'b0;
        for (int k = 0; k < 4; k++) d_access(1'b0, 4'h0, 32'(4 * k), 32'h0);
        drain();
    endtask

    task automatic test_addr_wrap();
        d_access(1'b0, 4'h0, 32'h400, 32'h0);
        drain();
        n_checks++;
        if (o_D_rdata !== ref_mem[0]) begin
            n_fail++;
            $display("FAIL addr_wrap: rdata %h, expected %h", o_D_rdata, ref_mem[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        i_D_req = 1'b1; i_D_we = 1'b0; i_D_addr = 32'h8;
        #1;
        n_checks++;
        if (o_D_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_gnt: gnt %b, expected 1", o_D_gnt);
        end
        step();
        i_D_req = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_busy: busy %b, expected 1", o_busy);
        end
        i_Rst_N = 1'b0;
        i_I_req = 1'b1; i_I_addr = 32'h30;
        i_D_req = 1'b1; i_D_addr = 32'h34;
        step();
        n_checks++;
        if (o_busy !== 1'b0 || o_D_rvalid !== 1'b0 || o_I_gnt !== 1'b0 || o_D_gnt !== 1'b0 || o_ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_reset: busy %b rvalid %b gnt %b%b en %b, expected 0 0 00 0",
                     o_busy, o_D_rvalid, o_I_gnt, o_D_gnt, o_ram_en);
        end
        i_Rst_N = 1'b1;
        #1;
        n_checks++;
        if (o_D_gnt !== 1'b1 || o_I_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_tie: gnt I%b D%b, expected I0 D1", o_I_gnt, o_D_gnt);
        end
        if (o_D_gnt === 1'b1) begin
            d_q_data.push_back(ref_mem[13]); d_q_due.push_back(cyc + 2);
        end
        step();
        i_I_req = 1'b0; i_D_req = 1'b0;
        drain();
        for (int k = 0; k < 3; k++) step();
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        i_Rst_N = 1'b0; i_I_req = 1'b0; i_I_addr = 32'h0;
        i_D_req = 1'b0; i_D_we = 1'b0; i_D_wmask = 4'h0; i_D_addr = 32'h0; i_D_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;
        preload();
        test_reset();
        test_single_i_read();
        test_byte_write();
        test_contention();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
